// File: rtl/sd_data_master_fsm_pkg.sv
// Shared constants and state encoding for the SD data-path sequencer.
// Status bit positions are shared with the interrupt logic that reads int_status_o.
package sd_data_master_fsm_pkg;

    localparam int DATA_TIMEOUT_W = 24;
    localparam int INT_DATA_SIZE  = 5;

    localparam int INT_DATA_CC    = 0;
    localparam int INT_DATA_EI    = 1;
    localparam int INT_DATA_CTE   = 2;
    localparam int INT_DATA_CCRCE = 3;
    localparam int INT_DATA_CFE   = 4;

    typedef enum logic [1:0] {
        IDLE          = 2'd0,
        START_TX_FIFO = 2'd1,
        START_RX_FIFO = 2'd2,
        DATA_TRANSFER = 2'd3
    } state_t;

endpackage

// File: rtl/sd_data_master_fsm.sv
// Data-path sequencer: starts TX/RX block transfers, watches FIFO health, CRC and
// a watchdog, and records one outcome per transfer in sticky status bits.
module sd_data_master_fsm #(
    parameter int DATA_TIMEOUT_W = sd_data_master_fsm_pkg::DATA_TIMEOUT_W,
    parameter int INT_DATA_SIZE  = sd_data_master_fsm_pkg::INT_DATA_SIZE
) (
    input  logic                      sd_clk,
    input  logic                      rst,
    input  logic                      start_tx_i,
    input  logic                      start_rx_i,
    input  logic [DATA_TIMEOUT_W-1:0] timeout_i,
    output logic                      d_write_o,
    output logic                      d_read_o,
    input  logic                      tx_fifo_empty_i,
    input  logic                      rx_fifo_full_i,
    input  logic                      xfr_complete_i,
    input  logic                      crc_ok_i,
    output logic [INT_DATA_SIZE-1:0]  int_status_o,
    input  logic                      int_status_rst_i
);
    import sd_data_master_fsm_pkg::*;

    localparam logic [DATA_TIMEOUT_W-1:0] WD_ONE = DATA_TIMEOUT_W'(1);

    state_t                    state_reg;
    state_t                    state_next;
    logic [DATA_TIMEOUT_W-1:0] watchdog_reg;
    logic                      tx_cycle_reg;
    logic                      trans_done_reg;
    logic                      d_write_reg;
    logic                      d_read_reg;
    logic [INT_DATA_SIZE-1:0]  int_status_reg;

    logic                      active;
    logic                      fifo_err;
    logic                      wd_expired;
    logic                      abort_event;
    logic                      end_event;
    logic [INT_DATA_SIZE-1:0]  status_set;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (start_tx_i)
                    state_next = START_TX_FIFO;
                else if (start_rx_i)
                    state_next = START_RX_FIFO;
            end
            START_TX_FIFO: begin
                if (!tx_fifo_empty_i && !xfr_complete_i)
                    state_next = DATA_TRANSFER;
            end
            START_RX_FIFO: begin
                if (!xfr_complete_i)
                    state_next = DATA_TRANSFER;
            end
            DATA_TRANSFER: begin
                if (trans_done_reg)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Outcome decode; priority FIFO error > timeout > completion, once per transfer.
    assign active      = (state_reg == DATA_TRANSFER) && !trans_done_reg;
    assign fifo_err    = tx_cycle_reg ? tx_fifo_empty_i : rx_fifo_full_i;
    assign wd_expired  = (timeout_i != '0) && (watchdog_reg >= timeout_i);
    assign abort_event = active && (fifo_err || wd_expired);
    assign end_event   = active && (fifo_err || wd_expired || xfr_complete_i);

    always_comb begin
        status_set = '0;
        if (active) begin
            if (fifo_err) begin
                status_set[INT_DATA_CFE] = 1'b1;
                status_set[INT_DATA_EI]  = 1'b1;
            end else if (wd_expired) begin
                status_set[INT_DATA_CTE] = 1'b1;
                status_set[INT_DATA_EI]  = 1'b1;
            end else if (xfr_complete_i) begin
                if (crc_ok_i) begin
                    status_set[INT_DATA_CC] = 1'b1;
                end else begin
                    status_set[INT_DATA_CCRCE] = 1'b1;
                    status_set[INT_DATA_EI]    = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge sd_clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            watchdog_reg   <= '0;
            tx_cycle_reg   <= 1'b0;
            trans_done_reg <= 1'b0;
            d_write_reg    <= 1'b0;
            d_read_reg     <= 1'b0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    d_write_reg    <= 1'b0;
                    d_read_reg     <= 1'b0;
                    tx_cycle_reg   <= 1'b0;
                    trans_done_reg <= 1'b0;
                    watchdog_reg   <= '0;
                end
                START_TX_FIFO: begin
                    tx_cycle_reg <= 1'b1;
                    if (!tx_fifo_empty_i)
                        d_write_reg <= 1'b1;
                end
                START_RX_FIFO: begin
                    d_read_reg <= 1'b1;
                end
                DATA_TRANSFER: begin
                    // Once done, outputs freeze so an abort pair lasts until IDLE clears it.
                    if (!trans_done_reg) begin
                        d_write_reg    <= abort_event;
                        d_read_reg     <= abort_event;
                        trans_done_reg <= end_event;
                        if (watchdog_reg != '1)
                            watchdog_reg <= watchdog_reg + WD_ONE;
                    end
                end
                default: begin
                    d_write_reg <= 1'b0;
                    d_read_reg  <= 1'b0;
                end
            endcase
        end
    end

    // A set in the same cycle as a clear wins so no outcome is lost.
    always_ff @(posedge sd_clk) begin
        if (rst)
            int_status_reg <= '0;
        else
            int_status_reg <= (int_status_rst_i ? '0 : int_status_reg) | status_set;
    end

    assign d_write_o    = d_write_reg;
    assign d_read_o     = d_read_reg;
    assign int_status_o = int_status_reg;

endmodule

// File: tb/tb_sd_data_master_fsm.sv
// Randomized bench: each transfer's outcome is predicted from the earliest of the
// FIFO-error, timeout and completion events, measured in data-phase cycles.
module tb_sd_data_master_fsm;

    localparam int TW  = 24;
    localparam int SW  = 5;
    localparam int INF = 1 << 30;

    logic          sd_clk = 1'b0;
    logic          rst = 1'b1;
    logic          start_tx_i = 1'b0;
    logic          start_rx_i = 1'b0;
    logic [TW-1:0] timeout_i = '0;
    logic          d_write_o;
    logic          d_read_o;
    logic          tx_fifo_empty_i = 1'b1;
    logic          rx_fifo_full_i = 1'b0;
    logic          xfr_complete_i = 1'b1;
    logic          crc_ok_i = 1'b1;
    logic [SW-1:0] int_status_o;
    logic          int_status_rst_i = 1'b0;

    int            checks = 0;
    int            errors = 0;
    int            xfer_no = 0;
    logic [SW-1:0] exp_status = '0;

    sd_data_master_fsm dut (
        .sd_clk           (sd_clk),
        .rst              (rst),
        .start_tx_i       (start_tx_i),
        .start_rx_i       (start_rx_i),
        .timeout_i        (timeout_i),
        .d_write_o        (d_write_o),
        .d_read_o         (d_read_o),
        .tx_fifo_empty_i  (tx_fifo_empty_i),
        .rx_fifo_full_i   (rx_fifo_full_i),
        .xfr_complete_i   (xfr_complete_i),
        .crc_ok_i         (crc_ok_i),
        .int_status_o     (int_status_o),
        .int_status_rst_i (int_status_rst_i)
    );

    always #5 sd_clk = ~sd_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (xfer %0d)", tag, got, exp, xfer_no);
        end
    endtask

    task automatic step();
        @(posedge sd_clk);
        #1;
    endtask

    // kc/kf: data-phase cycle at which completion / FIFO error is presented (INF = never).
    task automatic run_xfer(input bit tx, input int tmo, input int kc, input int kf,
                            input bit crc, input bit clr_same);
        int            kt;
        int            kwin;
        bit            abort;
        logic [SW-1:0] set_bits;
        logic [1:0]    start_outs;

        kt   = (tmo != 0) ? tmo : INF;
        kwin = kf;
        if (kt < kwin) kwin = kt;
        if (kc < kwin) kwin = kc;
        if (kf == kwin) begin
            set_bits = 5'b10010; abort = 1'b1;
        end else if (kt == kwin) begin
            set_bits = 5'b00110; abort = 1'b1;
        end else begin
            set_bits = crc ? 5'b00001 : 5'b01010; abort = 1'b0;
        end
        start_outs = tx ? 2'b10 : 2'b01;

        timeout_i       = TW'(tmo);
        xfr_complete_i  = 1'b1;
        tx_fifo_empty_i = tx;
        rx_fifo_full_i  = 1'b0;
        if (tx) begin
            start_tx_i = 1'b1;
            start_rx_i = ($urandom_range(0, 2) == 0);
        end else begin
            start_rx_i = 1'b1;
        end
        step();
        start_tx_i = 1'b0;
        start_rx_i = 1'b0;

        if (tx) begin
            repeat ($urandom_range(1, 3)) begin
                step();
                check("tx_wait_empty", {d_write_o, d_read_o}, 2'b00);
            end
            tx_fifo_empty_i = 1'b0;
            repeat ($urandom_range(1, 3)) begin
                step();
                check("tx_fill", {d_write_o, d_read_o}, 2'b10);
            end
        end else begin
            repeat ($urandom_range(1, 3)) begin
                step();
                check("rx_start", {d_write_o, d_read_o}, 2'b01);
            end
        end
        xfr_complete_i = 1'b0;
        step();
        check("start_exit", {d_write_o, d_read_o}, start_outs);

        for (int k = 0; k <= kwin; k++) begin
            if (tx) begin
                tx_fifo_empty_i = (k == kf);
                rx_fifo_full_i  = 1'($urandom_range(0, 1));
            end else begin
                rx_fifo_full_i  = (k == kf);
                tx_fifo_empty_i = 1'($urandom_range(0, 1));
            end
            xfr_complete_i   = (k >= kc);
            crc_ok_i         = (k == kc) ? crc : 1'($urandom_range(0, 1));
            int_status_rst_i = (k == kwin) && clr_same;
            step();
            if (k < kwin)
                check("data_busy", {d_write_o, d_read_o, int_status_o}, {2'b00, exp_status});
        end
        int_status_rst_i = 1'b0;
        exp_status = (clr_same ? '0 : exp_status) | set_bits;
        check("status", int_status_o, exp_status);
        check("end_outs", {d_write_o, d_read_o}, abort ? 2'b11 : 2'b00);

        tx_fifo_empty_i = 1'b1;
        rx_fifo_full_i  = 1'b0;
        xfr_complete_i  = 1'b1;
        step();
        check("hold_outs", {d_write_o, d_read_o}, abort ? 2'b11 : 2'b00);
        check("hold_status", int_status_o, exp_status);
        step();
        check("idle_outs", {d_write_o, d_read_o}, 2'b00);
        $display("xfer %0d tx=%0d tmo=%0d kc=%0d kf=%0d crc=%0d clr=%0d status=%b",
                 xfer_no, tx, tmo, kc, (kf == INF) ? -1 : kf, crc, clr_same, int_status_o);
        xfer_no++;
    endtask

    task automatic clear_status();
        int_status_rst_i = 1'b1;
        step();
        int_status_rst_i = 1'b0;
        exp_status = '0;
        check("status_clear", int_status_o, exp_status);
    endtask

    initial begin
        step();
        step();
        check("reset_outs", {d_write_o, d_read_o}, 2'b00);
        check("reset_status", int_status_o, 5'b00000);
        rst = 1'b0;
        step();

        // Directed scenarios from the test plan.
        run_xfer(1'b1, 100, 10, INF, 1'b1, 1'b0);
        clear_status();
        run_xfer(1'b0, 100, 7, INF, 1'b1, 1'b0);
        clear_status();
        run_xfer(1'b1, 100, 40, 5, 1'b1, 1'b0);
        clear_status();
        run_xfer(1'b0, 100, 40, 3, 1'b1, 1'b0);
        clear_status();
        run_xfer(1'b1, 100, 12, INF, 1'b0, 1'b0);
        clear_status();
        run_xfer(1'b0, 100, 0, INF, 1'b0, 1'b0);
        clear_status();
        run_xfer(1'b1, 100, INF, INF, 1'b1, 1'b0);
        clear_status();
        run_xfer(1'b0, 100, INF, INF, 1'b1, 1'b0);
        clear_status();
        run_xfer(1'b1, 0, 300, INF, 1'b1, 1'b0);
        run_xfer(1'b0, 0, 250, INF, 1'b1, 1'b1);
        run_xfer(1'b1, 20, 20, 20, 1'b1, 1'b0);
        run_xfer(1'b0, 15, 15, INF, 1'b1, 1'b0);

        // Abort mid-transfer through rst.
        start_tx_i      = 1'b1;
        tx_fifo_empty_i = 1'b0;
        timeout_i       = '0;
        step();
        start_tx_i     = 1'b0;
        xfr_complete_i = 1'b0;
        step();
        repeat (5) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_status = '0;
        check("midrst_outs", {d_write_o, d_read_o}, 2'b00);
        check("midrst_status", int_status_o, exp_status);
        xfr_complete_i = 1'b1;
        step();

        for (int n = 0; n < 30; n++) begin
            int tmo;
            int kf;
            case ($urandom_range(0, 3))
                0:       tmo = 0;
                1:       tmo = 100;
                default: tmo = int'($urandom_range(1, 60));
            endcase
            kf = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 80)) : INF;
            run_xfer(1'($urandom_range(0, 1)), tmo, int'($urandom_range(0, 120)), kf,
                     1'($urandom_range(0, 1)), ($urandom_range(0, 4) == 0));
            if ($urandom_range(0, 2) == 0)
                clear_status();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sd_data_master_fsm.md
Name: sd_data_master_fsm

Overview:
- Data-path sequencer of the SD card controller, clocked in the SD clock domain.
- Starts a block transfer on request: a TX (host-to-card) transfer, where the TX FIFO is filled first, or an RX (card-to-host) transfer.
- Issues one-cycle-class start/stop commands (d_write_o, d_read_o) to the serial data host and supervises FIFO health, CRC result and a watchdog timeout.
- Reports the outcome through sticky interrupt status bits.

Parameters:
- DATA_TIMEOUT_W, 24: width of timeout_i and of the internal watchdog counter.
- INT_DATA_SIZE, 5: width of int_status_o.

Ports:
- sd_clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start_tx_i  in  1  pulse: begin a TX transfer.
- start_rx_i  in  1  pulse: begin an RX transfer.
- timeout_i  in  DATA_TIMEOUT_W  watchdog limit in sd_clk cycles; 0 disables the watchdog.
- d_write_o  out  1  start write to serial host; when asserted together with d_read_o, means stop/abort.
- d_read_o  out  1  start read to serial host; when asserted together with d_write_o, means stop/abort.
- tx_fifo_empty_i  in  1  TX FIFO empty.
- rx_fifo_full_i  in  1  RX FIFO full.
- xfr_complete_i  in  1  serial host idle (1) / busy (0).
- crc_ok_i  in  1  CRC result, valid while xfr_complete_i rises.
- int_status_o  out  INT_DATA_SIZE  sticky status bits: bit0 CC (complete), bit1 EI (error), bit2 CTE (timeout), bit3 CCRCE (CRC error), bit4 CFE (FIFO error).
- int_status_rst_i  in  1  synchronous clear of int_status_o.

Behaviour:
- Reset: state IDLE, d_write_o=0, d_read_o=0, int_status_o=0, watchdog=0, tx_cycle=0, trans_done=0.
- Next-state logic is combinational; all outputs and flags are registered from the current state, i.e. one cycle after state entry.
- IDLE:
  - Drive d_write_o=0, d_read_o=0; clear tx_cycle, trans_done and watchdog.
  - start_tx_i -> START_TX_FIFO, else start_rx_i -> START_RX_FIFO. If both are high, TX wins.
- START_TX_FIFO:
  - tx_cycle<=1; d_write_o<=1 whenever !tx_fifo_empty_i.
  - Go to DATA_TRANSFER when !tx_fifo_empty_i && !xfr_complete_i; otherwise wait indefinitely.
- START_RX_FIFO:
  - d_read_o<=1.
  - Go to DATA_TRANSFER when !xfr_complete_i.
- DATA_TRANSFER (checks apply only while !trans_done):
  - Default: d_write_o<=0, d_read_o<=0, watchdog++.
  - FIFO error: tx_cycle && tx_fifo_empty_i, or !tx_cycle && rx_fifo_full_i. Set CFE|EI, trans_done<=1, d_write_o<=1, d_read_o<=1.
  - Else timeout: timeout_i!=0 && watchdog>=timeout_i. Set CTE|EI, trans_done<=1, both outputs <=1.
  - Else completion: xfr_complete_i=1. Set CC if crc_ok_i, else CCRCE|EI; trans_done<=1; outputs stay 0.
  - Exit: trans_done=1 -> IDLE. Does not wait for xfr_complete_i.
  - An abort pair (d_write_o=d_read_o=1) therefore stays high 2 cycles, until IDLE clears it.
- int_status_o:
  - Bits are sticky; they are never cleared by IDLE.
  - int_status_rst_i clears all bits on the next edge.
  - A set event in the same cycle as the clear wins, so no event is lost.
- Only one outcome is recorded per transfer; priority is FIFO error > timeout > completion.
- rst mid-transfer returns to IDLE with all outputs and status cleared.
- Watchdog: counter width DATA_TIMEOUT_W; saturates, never wraps.

Decomposition:
- Shared package holds:
  - INT_DATA_SIZE and bit indices INT_DATA_CC=0, EI=1, CTE=2, CCRCE=3, CFE=4;
  - DATA_TIMEOUT_W;
  - the state enum IDLE / START_TX_FIFO / START_RX_FIFO / DATA_TRANSFER.
- Single module, no sub-modules.

Test Plan:
- Normal TX, timeout_i=100:
  - pulse start_tx_i -> tx_cycle=1, outputs 0 while the FIFO is empty.
  - drop tx_fifo_empty_i -> d_write_o=1; drop xfr_complete_i -> d_write_o=0 within 2 cycles.
  - after 10 cycles raise xfr_complete_i with crc_ok_i=1 -> outputs stay 0, return to IDLE, int_status_o=5'b00001.
- Normal RX:
  - pulse start_rx_i -> d_read_o=1; xfr_complete_i=0 -> d_read_o=0.
  - completion with crc_ok_i=1 -> int_status_o=5'b00001; a one-cycle int_status_rst_i pulse -> 0.
- FIFO error:
  - TX with one-cycle tx_fifo_empty_i mid-transfer, or RX with one-cycle rx_fifo_full_i -> d_write_o=d_read_o=1.
  - returns to IDLE; int_status_o=5'b10010.
- CRC error: TX and RX completion with crc_ok_i=0 -> int_status_o=5'b01010.
- Timeout: timeout_i=100, xfr_complete_i held 0 -> after ~100 cycles both outputs 1, IDLE, int_status_o=5'b00110; same for RX.
- timeout_i=0: a long TX or RX transfer never times out; completion -> 5'b00001.
